// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multi-cycle CPU control sequencer with memory-wait timeout
module mc_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    input  logic       stall,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_load,
    output logic       pc_load,
    output logic [1:0] pc_sel,
    output logic       rf_we,
    output logic [2:0] state,
    output logic       err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b110000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_REG = 2'b11;

    state_t     cur, nxt;
    logic [5:0] op_q, fn_q;
    logic [3:0] wait_cnt;
    logic       err_q;

    logic       req_c, we_c, irl_c, pcl_c, rfw_c, waiting;
    logic [1:0] psel_c;
    logic       timeout_hit;

    // Fires on the TIMEOUT-th consecutive unacknowledged cycle.
    assign timeout_hit = (int'(wait_cnt) + 1 >= TIMEOUT);

    always_comb begin
        nxt     = cur;
        req_c   = 1'b0;
        we_c    = 1'b0;
        irl_c   = 1'b0;
        pcl_c   = 1'b0;
        psel_c  = PC_SEQ;
        rfw_c   = 1'b0;
        waiting = 1'b0;
        case (cur)
            S_FETCH: begin
                if (!stall) begin
                    req_c   = 1'b1;
                    waiting = 1'b1;
                    if (mem_ready) begin
                        irl_c = 1'b1;
                        nxt   = S_DECODE;
                    end else if (timeout_hit) begin
                        nxt = S_ERR;
                    end
                end
            end
            S_DECODE: nxt = S_EXEC;
            S_EXEC: begin
                nxt = S_FETCH;
                case (op_q)
                    OP_RTYPE: begin
                        if (fn_q == FN_JR) begin
                            pcl_c  = 1'b1;
                            psel_c = PC_REG;
                        end else begin
                            nxt = S_WB;
                        end
                    end
                    OP_ADDI, OP_ANDI: nxt = S_WB;
                    OP_LW, OP_SW:     nxt = S_MEM;
                    OP_BEQ: begin
                        pcl_c  = 1'b1;
                        psel_c = zero ? PC_BR : PC_SEQ;
                    end
                    OP_BNE: begin
                        pcl_c  = 1'b1;
                        psel_c = zero ? PC_SEQ : PC_BR;
                    end
                    OP_J: begin
                        pcl_c  = 1'b1;
                        psel_c = PC_JMP;
                    end
                    OP_JAL: begin
                        pcl_c  = 1'b1;
                        psel_c = PC_JMP;
                        rfw_c  = 1'b1;
                    end
                    default: pcl_c = 1'b1;
                endcase
            end
            S_MEM: begin
                req_c   = 1'b1;
                we_c    = (op_q == OP_SW);
                waiting = 1'b1;
                if (mem_ready) begin
                    if (op_q == OP_SW) begin
                        pcl_c = 1'b1;
                        nxt   = S_FETCH;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (timeout_hit) begin
                    nxt = S_ERR;
                end
            end
            S_WB: begin
                rfw_c = 1'b1;
                pcl_c = 1'b1;
                nxt   = S_FETCH;
            end
            S_ERR:   nxt = S_ERR;
            default: nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur      <= S_FETCH;
            op_q     <= 6'd0;
            fn_q     <= 6'd0;
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE) begin
                op_q <= opcode;
                fn_q <= funct;
            end
            if (nxt != cur || !waiting)
                wait_cnt <= 4'd0;
            else if (wait_cnt != 4'hF)
                wait_cnt <= wait_cnt + 4'd1;
            if (nxt == S_ERR)
                err_q <= 1'b1;
        end
    end

    // Reset is synchronous, so outputs are masked while it is held low.
    assign mem_req = rst & req_c;
    assign mem_we  = rst & we_c;
    assign ir_load = rst & irl_c;
    assign pc_load = rst & pcl_c;
    assign pc_sel  = rst ? psel_c : 2'b00;
    assign rf_we   = rst & rfw_c;
    assign state   = rst ? cur : S_FETCH;
    assign err     = rst & err_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - directed vector bench for mc_sequencer
module tb_mc_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero, mem_ready, stall;
    logic       mem_req, mem_we, ir_load, pc_load, rf_we, err;
    logic [1:0] pc_sel;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    mc_sequencer #(.TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel), .rf_we(rf_we),
        .state(state), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       pcl;
        logic [1:0] psel;
        logic       rfw;
        logic [2:0] nxt;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH with mem_ready=1: runs FETCH and DECODE, ends settled in EXEC.
    task automatic to_exec(input logic [5:0] op, input logic [5:0] fn);
        stall = 1'b0; mem_ready = 1'b1; opcode = op; funct = fn;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1; stall = 1'b1; mem_ready = 1'b0;
        #1;
    endtask

    initial begin
        vecs[0]  = '{"add",   6'b000000, 6'b100000, 1'b0, 1'b0, 2'd0, 1'b0, 3'd4};
        vecs[1]  = '{"jr",    6'b000000, 6'b001000, 1'b0, 1'b1, 2'd3, 1'b0, 3'd0};
        vecs[2]  = '{"addi",  6'b001000, 6'b000000, 1'b0, 1'b0, 2'd0, 1'b0, 3'd4};
        vecs[3]  = '{"andi",  6'b001100, 6'b000000, 1'b0, 1'b0, 2'd0, 1'b0, 3'd4};
        vecs[4]  = '{"lw",    6'b110000, 6'b000000, 1'b0, 1'b0, 2'd0, 1'b0, 3'd3};
        vecs[5]  = '{"sw",    6'b101011, 6'b000000, 1'b0, 1'b0, 2'd0, 1'b0, 3'd3};
        vecs[6]  = '{"beq_t", 6'b000100, 6'b000000, 1'b1, 1'b1, 2'd1, 1'b0, 3'd0};
        vecs[7]  = '{"beq_n", 6'b000100, 6'b000000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0};
        vecs[8]  = '{"bne_t", 6'b000101, 6'b000000, 1'b0, 1'b1, 2'd1, 1'b0, 3'd0};
        vecs[9]  = '{"bne_n", 6'b000101, 6'b000000, 1'b1, 1'b1, 2'd0, 1'b0, 3'd0};
        vecs[10] = '{"j",     6'b000010, 6'b000000, 1'b0, 1'b1, 2'd2, 1'b0, 3'd0};
        vecs[11] = '{"jal",   6'b000011, 6'b000000, 1'b0, 1'b1, 2'd2, 1'b1, 3'd0};
        vecs[12] = '{"nop",   6'b111111, 6'b000000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0};
        vecs[13] = '{"undef", 6'b010101, 6'b000000, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0};

        rst = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0;
        mem_ready = 1'b1; stall = 1'b0;
        tick();
        tick();
        chk("rst_state", state, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_ir_load", ir_load, 0);
        chk("rst_err", err, 0);
        rst = 1'b1; stall = 1'b1;
        #1;

        foreach (vecs[i]) begin
            zero = vecs[i].z;
            stall = 1'b0; mem_ready = 1'b1; opcode = vecs[i].op; funct = vecs[i].fn;
            #1;
            chk({vecs[i].name, "_fetch_ir_load"}, ir_load, 1);
            tick();
            chk({vecs[i].name, "_decode"}, state, 1);
            tick();
            opcode = 6'b111110; funct = 6'b001000;
            #1;
            chk({vecs[i].name, "_exec_state"}, state, 2);
            chk({vecs[i].name, "_exec_pc_load"}, pc_load, vecs[i].pcl);
            chk({vecs[i].name, "_exec_pc_sel"}, pc_sel, vecs[i].psel);
            chk({vecs[i].name, "_exec_rf_we"}, rf_we, vecs[i].rfw);
            chk({vecs[i].name, "_exec_mem_req"}, mem_req, 0);
            tick();
            chk({vecs[i].name, "_after_exec"}, state, vecs[i].nxt);
            stall = 1'b1;
            for (int k = 0; k < 4 && state != 3'd0; k++) tick();
            chk({vecs[i].name, "_back_to_fetch"}, state, 0);
        end

        // add: WB cycle drives rf_we and pc_load with sequential PC
        to_exec(6'b000000, 6'b100000);
        tick();
        chk("add_wb_state", state, 4);
        chk("add_wb_rf_we", rf_we, 1);
        chk("add_wb_pc_load", pc_load, 1);
        chk("add_wb_pc_sel", pc_sel, 0);
        tick();
        chk("add_end_state", state, 0);

        // lw with ack delayed three cycles in MEM
        to_exec(6'b110000, 6'b000000);
        mem_ready = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("lw_wait_state", state, 3);
            chk("lw_wait_req", mem_req, 1);
            chk("lw_wait_we", mem_we, 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        chk("lw_ack_req", mem_req, 1);
        chk("lw_ack_we", mem_we, 0);
        chk("lw_ack_pc_load", pc_load, 0);
        tick();
        chk("lw_wb_state", state, 4);
        chk("lw_wb_rf_we", rf_we, 1);
        stall = 1'b1;
        tick();

        // sw: write qualifier in MEM, pc_load on ack, no register write
        to_exec(6'b101011, 6'b000000);
        tick();
        chk("sw_mem_state", state, 3);
        chk("sw_mem_we", mem_we, 1);
        chk("sw_pc_load", pc_load, 1);
        chk("sw_rf_we", rf_we, 0);
        stall = 1'b1;
        tick();
        chk("sw_end_state", state, 0);

        // stall holds FETCH with no request; ready is ignored then
        stall = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("stall_mem_req", mem_req, 0);
            chk("stall_ir_load", ir_load, 0);
            tick();
        end
        chk("stall_state", state, 0);
        chk("stall_err", err, 0);

        // 15 unacknowledged fetch cycles -> ERR
        stall = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        chk("to_pre_state", state, 0);
        chk("to_pre_err", err, 0);
        tick();
        chk("to_state", state, 5);
        chk("to_err", err, 1);
        mem_ready = 1'b1;
        #1;
        chk("err_mem_req", mem_req, 0);
        chk("err_ir_load", ir_load, 0);
        tick();
        chk("err_sticky_state", state, 5);
        rst = 1'b0;
        #1;
        chk("err_rst_out_state", state, 0);
        chk("err_rst_out_err", err, 0);
        tick();
        rst = 1'b1; stall = 1'b1; mem_ready = 1'b0;
        #1;
        chk("err_clear_state", state, 0);
        chk("err_clear_err", err, 0);

        // ready arriving on the timeout cycle wins
        stall = 1'b0; mem_ready = 1'b0; opcode = 6'b111111; funct = 6'd0;
        for (int k = 0; k < 14; k++) tick();
        mem_ready = 1'b1;
        #1;
        chk("race_ir_load", ir_load, 1);
        tick();
        chk("race_state", state, 1);
        chk("race_err", err, 0);
        stall = 1'b1;
        tick();
        tick();
        chk("race_back_fetch", state, 0);

        // reset during lw MEM: no write-back
        to_exec(6'b110000, 6'b000000);
        mem_ready = 1'b0;
        tick();
        chk("rstmem_state", state, 3);
        rst = 1'b0;
        #1;
        chk("rstmem_rf_we", rf_we, 0);
        chk("rstmem_mem_req", mem_req, 0);
        tick();
        rst = 1'b1; stall = 1'b1; mem_ready = 1'b1;
        #1;
        chk("rstmem_fetch", state, 0);
        chk("rstmem_rf_we_after", rf_we, 0);
        tick();
        chk("rstmem_stay_fetch", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: opcode  in  6  IR[31:26]; valid from DECODE onward.
REQ-004 SHALL have ports: funct  in  6  IR[5:0]; valid from DECODE onward.
REQ-005 SHALL have ports: zero  in  1  ALU zero flag; valid in EXEC.
REQ-006 SHALL have ports: mem_ready  in  1  memory acknowledge for the current mem_req.
REQ-007 SHALL have ports: stall  in  1  hazard hold; sampled in FETCH only.
REQ-008 SHALL have ports: mem_req  out  1  memory access request (read unless mem_we).
REQ-009 SHALL have ports: mem_we  out  1  write qualifier for mem_req.
REQ-010 SHALL have ports: ir_load  out  1  one-cycle IR load pulse.
REQ-011 SHALL have ports: pc_load  out  1  one-cycle PC update pulse.
REQ-012 SHALL have ports: pc_sel  out  2  00 PC+4, 01 branch target, 10 jump target, 11 register (jr).
REQ-013 SHALL have ports: rf_we  out  1  one-cycle register-file write pulse.
REQ-014 SHALL have ports: state  out  3  current state code.
REQ-015 SHALL have ports: err  out  1  sticky memory-timeout flag.
REQ-016 SHALL have parameter: TIMEOUT, default 15, maximum wait cycles for mem_ready.

Function
REQ-017 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5.
REQ-018 SHALL drive all outputs combinationally from state, the latched opcode/funct, zero and mem_ready; pulses occur in the cycle their transition fires.
REQ-019 FETCH, stall=1: mem_req=0, remain in FETCH, wait counter held at 0.
REQ-020 FETCH, stall=0: mem_req=1, mem_we=0; on mem_ready=1, ir_load=1 and go to DECODE.
REQ-021 DECODE: latch opcode and funct into internal registers; go to EXEC next cycle unconditionally.
REQ-022 EXEC, R-type (000000) other than funct 001000, addi (001000), andi (001100): go to WB.
REQ-023 EXEC, lw (110000), sw (101011): go to MEM.
REQ-024 EXEC, beq (000100): pc_load=1, pc_sel=01 if zero=1 else 00; go to FETCH.
REQ-025 EXEC, bne (000101): pc_load=1, pc_sel=01 if zero=0 else 00; go to FETCH.
REQ-026 EXEC, j (000010): pc_load=1, pc_sel=10; go to FETCH.
REQ-027 EXEC, jal (000011): pc_load=1, pc_sel=10, rf_we=1; go to FETCH.
REQ-028 EXEC, jr (opcode 000000, funct 001000): pc_load=1, pc_sel=11; go to FETCH.
REQ-029 EXEC, nop (111111) or any undefined opcode: pc_load=1, pc_sel=00; go to FETCH.
REQ-030 MEM: mem_req=1, mem_we=1 for sw only.
REQ-031 MEM, on mem_ready=1: lw goes to WB; sw asserts pc_load=1 with pc_sel=00 and goes to FETCH.
REQ-032 WB: rf_we=1, pc_load=1, pc_sel=00; go to FETCH.
REQ-033 SHALL count consecutive cycles in FETCH (stall=0) or MEM with mem_ready=0, using a 4-bit counter that saturates.
REQ-034 SHALL clear the wait counter on any state change.
REQ-035 When the wait count reaches TIMEOUT with mem_ready still 0: go to ERR, set err=1.
REQ-036 ERR: all pulses, mem_req and mem_we SHALL be 0; remain in ERR until reset.
REQ-037 mem_ready while mem_req=0 SHALL be ignored.
REQ-038 mem_ready arriving in the same cycle the timeout is reached SHALL win: the transition proceeds and err stays 0.
REQ-039 Outputs not named for a state SHALL be 0 in that state; pc_sel SHALL be 00 whenever pc_load=0.
REQ-040 Minimum latency with mem_ready tied high: R-type 4 cycles, lw 5, sw 4, branch/jump 3.

Reset
REQ-041 rst=0 at a clock edge SHALL force state=FETCH, clear err, the wait counter and the latched opcode/funct, in any state including mid-MEM and ERR.
REQ-042 While rst=0, all outputs SHALL be 0 except state=0.

Verification
REQ-043 R-type add (funct 100000), mem_ready=1 -> states 0,1,2,4,0; ir_load in cycle 1, rf_we and pc_load in cycle 4, pc_sel=00.
REQ-044 beq with zero=1 -> pc_load, pc_sel=01 in EXEC; repeat with zero=0 -> pc_sel=00; bne gives the inverse results.
REQ-045 lw with mem_ready delayed 3 cycles in MEM -> mem_req=1 and mem_we=0 held 4 cycles, then WB with rf_we=1.
REQ-046 sw -> mem_we=1 in MEM; pc_load on ack; rf_we never asserted.
REQ-047 stall=1 for 5 cycles in FETCH -> mem_req=0 and no timeout; stall released with mem_ready=0 for 15 cycles -> ERR, err=1; rst=0 -> FETCH, err=0.
REQ-048 rst=0 asserted in MEM during an lw -> next state FETCH, rf_we never asserted; jr and jal produce pc_sel=11 and pc_sel=10+rf_we respectively.
